// File: rtl/sram_axil_slave_pkg.sv
// =============================================================================
// sram_axil_slave_pkg : shared FSM state encodings and AXI response codes
// Revision 1.0
// =============================================================================
`default_nettype none

package sram_axil_slave_pkg;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_WAIT = 2'd1,
        R_RESP = 2'd2
    } rd_state_t;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_WAIT = 2'd1,
        W_RESP = 2'd2
    } wr_state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam int         CNT_W       = 4;

endpackage

`default_nettype wire

// File: rtl/sram_bytes_mem.sv
// =============================================================================
// sram_bytes_mem : 32-bit word array, synchronous byte-masked write, registered read
// Revision 1.0
// =============================================================================
`default_nettype none

module sram_bytes_mem #(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [3:0]    wstrb,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] r_mem [DEPTH];
    logic [31:0] r_rdata;

    // Read and write share an edge, so a colliding read sees the old word.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (wstrb[i]) begin
                    r_mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
        if (re) begin
            r_rdata <= r_mem[raddr];
        end
    end

    assign rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/sram_axil_slave.sv
// =============================================================================
// sram_axil_slave : AXI4-Lite slave over a word SRAM, independent read/write FSMs
// Revision 1.0
// =============================================================================
`default_nettype none

module sram_axil_slave
    import sram_axil_slave_pkg::*;
#(
    parameter logic [31:0] BASE   = 32'h8000_0000,
    parameter int          DEPTH  = 1024,
    parameter int          RD_LAT = 1,
    parameter int          WR_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] araddr,
    input  logic        arvalid,
    output logic        arready,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rvalid,
    input  logic        rready,
    input  logic [31:0] awaddr,
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wvalid,
    output logic        wready,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready
);

    localparam int               c_AW     = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] c_RD_LAT = CNT_W'(RD_LAT);
    localparam logic [CNT_W-1:0] c_WR_LAT = CNT_W'(WR_LAT);

    rd_state_t        r_rstate, w_rstate_nxt;
    logic [CNT_W-1:0] r_rcnt;
    logic [31:0]      r_araddr;
    wr_state_t        r_wstate, w_wstate_nxt;
    logic [CNT_W-1:0] r_wcnt;
    logic [31:0]      r_awaddr, r_wdata;
    logic [3:0]       r_wstrb;
    logic             r_aw_got, r_w_got;

    logic        w_ar_hs, w_aw_hs, w_w_hs, w_aw_have, w_w_have;
    logic [31:0] w_roff, w_woff, w_mem_rdata;
    logic        w_rd_ok, w_wr_ok, w_rd_en, w_wr_en, w_unused_bits;

    assign w_ar_hs   = arvalid & arready;
    assign w_aw_hs   = awvalid & awready;
    assign w_w_hs    = wvalid & wready;
    assign w_aw_have = r_aw_got | w_aw_hs;
    assign w_w_have  = r_w_got | w_w_hs;

    // Offsets wrap below BASE, so one upper-bit test covers both range ends.
    assign w_roff        = r_araddr - BASE;
    assign w_woff        = r_awaddr - BASE;
    assign w_rd_ok       = (w_roff[31:c_AW+2] == '0);
    assign w_wr_ok       = (w_woff[31:c_AW+2] == '0);
    assign w_unused_bits = ^{w_roff[1:0], w_woff[1:0]};

    assign w_rd_en = (r_rstate == R_WAIT) && (r_rcnt == '0);
    assign w_wr_en = (r_wstate == W_WAIT) && (r_wcnt == '0) && w_wr_ok;

    // ---------------- read FSM ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rstate <= R_IDLE;
            r_rcnt   <= '0;
            r_araddr <= '0;
        end else begin
            r_rstate <= w_rstate_nxt;
            if (w_ar_hs) begin
                r_araddr <= araddr;
                r_rcnt   <= c_RD_LAT;
            end else if (r_rstate == R_WAIT && r_rcnt != '0) begin
                r_rcnt <= r_rcnt - 1'b1;
            end
        end
    end

    always_comb begin
        w_rstate_nxt = r_rstate;
        unique case (r_rstate)
            R_IDLE:  if (w_ar_hs)        w_rstate_nxt = R_WAIT;
            R_WAIT:  if (r_rcnt == '0)   w_rstate_nxt = R_RESP;
            R_RESP:  if (rready)         w_rstate_nxt = R_IDLE;
            default:                     w_rstate_nxt = R_IDLE;
        endcase
    end

    always_comb begin
        arready = (r_rstate == R_IDLE);
        rvalid  = (r_rstate == R_RESP);
        rresp   = RESP_OKAY;
        rdata   = '0;
        if (r_rstate == R_RESP) begin
            rresp = w_rd_ok ? RESP_OKAY : RESP_SLVERR;
            rdata = w_rd_ok ? w_mem_rdata : '0;
        end
    end

    // ---------------- write FSM ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wstate <= W_IDLE;
            r_wcnt   <= '0;
            r_aw_got <= 1'b0;
            r_w_got  <= 1'b0;
            r_awaddr <= '0;
            r_wdata  <= '0;
            r_wstrb  <= '0;
        end else begin
            r_wstate <= w_wstate_nxt;
            if (w_aw_hs) r_awaddr <= awaddr;
            if (w_w_hs) begin
                r_wdata <= wdata;
                r_wstrb <= wstrb;
            end
            if (r_wstate == W_IDLE) begin
                if (w_aw_have && w_w_have) begin
                    r_aw_got <= 1'b0;
                    r_w_got  <= 1'b0;
                    r_wcnt   <= c_WR_LAT;
                end else begin
                    r_aw_got <= w_aw_have;
                    r_w_got  <= w_w_have;
                end
            end else if (r_wstate == W_WAIT && r_wcnt != '0) begin
                r_wcnt <= r_wcnt - 1'b1;
            end
        end
    end

    always_comb begin
        w_wstate_nxt = r_wstate;
        unique case (r_wstate)
            W_IDLE:  if (w_aw_have && w_w_have) w_wstate_nxt = W_WAIT;
            W_WAIT:  if (r_wcnt == '0)          w_wstate_nxt = W_RESP;
            W_RESP:  if (bready)                w_wstate_nxt = W_IDLE;
            default:                            w_wstate_nxt = W_IDLE;
        endcase
    end

    always_comb begin
        awready = (r_wstate == W_IDLE) && !r_aw_got;
        wready  = (r_wstate == W_IDLE) && !r_w_got;
        bvalid  = (r_wstate == W_RESP);
        bresp   = RESP_OKAY;
        if (r_wstate == W_RESP && !w_wr_ok) begin
            bresp = RESP_SLVERR;
        end
    end

    sram_bytes_mem #(
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (w_wr_en),
        .wstrb (r_wstrb),
        .waddr (w_woff[c_AW+1:2]),
        .wdata (r_wdata),
        .re    (w_rd_en),
        .raddr (w_roff[c_AW+1:2]),
        .rdata (w_mem_rdata)
    );

endmodule

`default_nettype wire
